// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
// Time-multiplexes one shared BCD-to-seven-segment decoder across four
// digits. A 16-bit display register holds four BCD digits. Each digit is lit
// for REFRESH_DIV cycles. It is followed by GUARD_CYC anode-off cycles.
// Digits holding a non-BCD code are blanked, and leading zeros can be
// suppressed.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   enable    in   1  scanning runs while high
//   load      in   1  capture value into the display register on this edge
//   value     in  16  four BCD digits, [3:0] = digit0 (rightmost)
//   blank_lz  in   1  suppress leading zeros (digit0 is never suppressed)
//   load_ack  out  1  one-cycle pulse in the cycle after a capture
//   err       out  1  captured value contains a nibble greater than 9
//   bcd_out   out  4  digit code for the shared decoder
//   an_n      out  4  active-low anode select, bit i drives digit i
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic        load_ack,
   output logic        err,
   output logic [3:0]  bcd_out,
   output logic [3:0]  an_n
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYC > 0) ? GW'(GUARD_CYC - 1) : {GW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_GUARD = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     idx_q, idx_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [GW-1:0]  guard_q, guard_d;
   logic [15:0]    disp_q, disp_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;

   // True when any of the four nibbles is not a valid BCD digit.
   function automatic logic has_bad_nibble(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction

   // Selects digit i of the display register.
   function automatic logic [3:0] nibble_at(input logic [15:0] d, input logic [1:0] i);
      logic [3:0] n;
      case (i)
         2'd0:    n = d[3:0];
         2'd1:    n = d[7:4];
         2'd2:    n = d[11:8];
         2'd3:    n = d[15:12];
         default: n = 4'd0;
      endcase
      return n;
   endfunction

   // A digit is dark when it is non-BCD, or when it is a leading zero
   // (it and every digit to its left are zero) under suppression.
   function automatic logic is_blanked(input logic [15:0] d, input logic [1:0] i,
                                       input logic blz);
      logic lead_zero;
      case (i)
         2'd1:    lead_zero = (d[15:4]  == 12'd0);
         2'd2:    lead_zero = (d[15:8]  == 8'd0);
         2'd3:    lead_zero = (d[15:12] == 4'd0);
         default: lead_zero = 1'b0;
      endcase
      return (nibble_at(d, i) > 4'd9) || (blz && lead_zero);
   endfunction

   // Scan FSM: next state, digit index and slot counters.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      presc_d = presc_q;
      guard_d = guard_q;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = 2'd0;
         presc_d = {PW{1'b0}};
         guard_d = {GW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SCAN;
               idx_d   = 2'd0;
               presc_d = {PW{1'b0}};
               guard_d = {GW{1'b0}};
            end
            ST_SCAN: begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = {PW{1'b0}};
                  idx_d   = idx_q + 2'd1;
                  guard_d = {GW{1'b0}};
                  // With no guard time the next digit lights immediately.
                  if (GUARD_CYC > 0) begin
                     state_d = ST_GUARD;
                  end else begin
                     state_d = ST_SCAN;
                  end
               end else begin
                  presc_d = presc_q + PW'(1'b1);
               end
            end
            ST_GUARD: begin
               if (guard_q == GUARD_LAST) begin
                  state_d = ST_SCAN;
                  guard_d = {GW{1'b0}};
               end else begin
                  guard_d = guard_q + GW'(1'b1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = 2'd0;
               presc_d = {PW{1'b0}};
               guard_d = {GW{1'b0}};
            end
         endcase
      end
   end

   // Capture path: display register, acknowledge pulse and error flag.
   always_comb begin
      ack_d = load;
      if (load) begin
         disp_d = value;
         err_d  = has_bad_nibble(value);
      end else begin
         disp_d = disp_q;
         err_d  = err_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         presc_q <= {PW{1'b0}};
         guard_q <= {GW{1'b0}};
         disp_q  <= 16'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         guard_q <= guard_d;
         disp_q  <= disp_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Digit drive: only a non-blanked digit in SCAN reaches the decoder.
   always_comb begin
      bcd_out = 4'd0;
      an_n    = 4'b1111;
      if (state_q == ST_SCAN && !is_blanked(disp_q, idx_q, blank_lz)) begin
         bcd_out = nibble_at(disp_q, idx_q);
         an_n    = ~(4'b0001 << idx_q);
      end else begin
         bcd_out = 4'd0;
         an_n    = 4'b1111;
      end
   end

   assign load_ack = ack_q;
   assign err      = err_q;

endmodule
